// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, default geometry and oversample markers.
// Used by the receiver (and by the transmitter that reuses uart_baud_gen).
package uart_pkg;

    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int DVSR_W_DEF  = 11;

    localparam int MID_START = 7;
    localparam int LAST_OS   = 15;

    // Oversample index is 5 bits so 1.5 and 2 stop bits (24/32 ticks) still fit.
    localparam int OS_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: divisor and serial line in, byte/strobe/status out.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
    parameter int DBIT   = 8,
    parameter int DVSR_W = 11
);
    logic [DVSR_W-1:0] dvsr;
    logic              rx;
    logic [DBIT-1:0]   dout;
    logic              rx_done_tick;
    logic              frame_err;
`ifdef UART_RX_PARITY_EN
    logic              parity_err;

    modport master (output dvsr, rx, input dout, rx_done_tick, frame_err, parity_err);
    modport slave  (input dvsr, rx, output dout, rx_done_tick, frame_err, parity_err);
`else
    modport master (output dvsr, rx, input dout, rx_done_tick, frame_err);
    modport slave  (input dvsr, rx, output dout, rx_done_tick, frame_err);
`endif
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running divider: one-cycle tick every dvsr+1 clocks (16x the bit rate).
// dvsr is compared live; after a decrease below cnt the counter wraps naturally.
module uart_baud_gen #(
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr_i,
    output logic              tick_o
);
    logic [DVSR_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == dvsr_i);
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_core.sv
// 16x-oversampling UART receiver feeding the rx FIFO via a one-cycle rx_done_tick.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int DVSR_W  = DVSR_W_DEF
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);
    localparam int NW = $clog2(DBIT);

    logic            tick;
    logic            rx_meta_q, rx_s_q;
    state_e          state_q;
    logic            armed_q;
    logic [OS_W-1:0] s_q;
    logic [NW-1:0]   n_q;
    logic [DBIT-1:0] b_q, dout_q;
    logic            done_q, ferr_q;
`ifdef UART_RX_PARITY_EN
    logic            par_q, perr_q;
`endif

    uart_baud_gen #(.DVSR_W(DVSR_W)) u_baud (
        .clk    (clk),
        .reset  (reset),
        .dvsr_i (bus.dvsr),
        .tick_o (tick)
    );

    // Idle-high reset values keep a reset release from looking like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // armed blocks a stuck-low line from re-triggering after a break frame
                    if (rx_s_q) armed_q <= 1'b1;
                    else if (armed_q) begin
                        state_q <= START;
                        s_q     <= '0;
                    end
                end
                START: if (tick) begin
                    if (s_q == OS_W'(MID_START)) begin
                        if (!rx_s_q) begin
                            state_q <= DATA;
                            s_q     <= '0;
                            n_q     <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
                DATA: if (tick) begin
                    if (s_q == OS_W'(LAST_OS)) begin
                        s_q <= '0;
                        b_q <= {rx_s_q, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT-1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            n_q <= n_q + 1'b1;
                        end
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick) begin
                    if (s_q == OS_W'(LAST_OS)) begin
                        par_q   <= rx_s_q;
                        s_q     <= '0;
                        state_q <= STOP;
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
`endif
                STOP: if (tick) begin
                    if (s_q == OS_W'(SB_TICK-1)) begin
                        dout_q  <= b_q;
                        ferr_q  <= ~rx_s_q;
                        done_q  <= 1'b1;
                        armed_q <= 1'b0;
                        state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_q  <= ^{b_q, par_q};
`endif
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err   = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed + randomized bench for uart_rx_core; model = the frames the bench serialises.
module tb_uart_rx_core;
    localparam int DBIT   = 8;
    localparam int DVSR_W = 11;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if #(.DBIT(DBIT), .DVSR_W(DVSR_W)) bus ();

    uart_rx_core #(.DBIT(DBIT), .SB_TICK(16), .DVSR_W(DVSR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } rec_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   back2back = 0;
    int   bit_clk;
    rec_t got[$];
    logic prev_done = 1'b0;

    // Monitor: capture every strobe away from the active edge.
    always @(negedge clk) begin
        if (bus.rx_done_tick === 1'b1) begin
            rec_t r;
            r.d  = bus.dout;
            r.fe = bus.frame_err;
`ifdef UART_RX_PARITY_EN
            r.pe = bus.parity_err;
`else
            r.pe = 1'b0;
`endif
            got.push_back(r);
            if (prev_done) back2back++;
        end
        prev_done = (bus.rx_done_tick === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int cycles);
        bus.rx = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic set_dvsr(input logic [DVSR_W-1:0] d);
        bus.dvsr = d;
        bit_clk  = 16 * (int'(d) + 1);
        // let a wrapped counter come back round before the next frame
        hold(1'b1, 2100 + bit_clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop_v);
        hold(1'b0, bit_clk);
        for (int i = 0; i < 8; i++) hold(d[i], bit_clk);
`ifdef UART_RX_PARITY_EN
        hold(^d, bit_clk);
`endif
        hold(stop_v, bit_clk);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_par(input logic [7:0] d, input logic p);
        hold(1'b0, bit_clk);
        for (int i = 0; i < 8; i++) hold(d[i], bit_clk);
        hold(p, bit_clk);
        hold(1'b1, bit_clk);
    endtask
`endif

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic fe, input logic pe);
        rec_t r;
        for (int i = 0; i < 12 * bit_clk && got.size() == 0; i++) @(posedge clk);
        chk({tag, "_strobe"}, 32'(got.size() > 0), 32'd1);
        if (got.size() > 0) begin
            r = got.pop_front();
            chk({tag, "_dout"}, 32'(r.d), 32'(d));
            chk({tag, "_ferr"}, 32'(r.fe), 32'(fe));
`ifdef UART_RX_PARITY_EN
            chk({tag, "_perr"}, 32'(r.pe), 32'(pe));
`else
            if (pe) chk({tag, "_perr"}, 32'(r.pe), 32'(pe));
`endif
        end
    endtask

    task automatic expect_none(input string tag);
        chk(tag, 32'(got.size()), 32'd0);
        got.delete();
    endtask

    initial begin
        logic [7:0] rd, pat;
        logic       rs;
        bus.rx   = 1'b1;
        bus.dvsr = 11'd3;
        bit_clk  = 64;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_done", 32'(bus.rx_done_tick), 32'd0);
        chk("rst_ferr", 32'(bus.frame_err), 32'd0);
        reset = 1'b1;
        hold(1'b1, bit_clk);

        send(8'hA5, 1'b1);
        expect_frame("a5", 8'hA5, 1'b0, 1'b0);
        expect_none("a5_extra");

        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h3C, 1'b1);
        expect_frame("b2b0", 8'h00, 1'b0, 1'b0);
        expect_frame("b2b1", 8'hFF, 1'b0, 1'b0);
        expect_frame("b2b2", 8'h3C, 1'b0, 1'b0);
        expect_none("b2b_extra");

        hold(1'b0, 20);
        hold(1'b1, 3 * bit_clk);
        expect_none("glitch");
        send(8'h55, 1'b1);
        expect_frame("post_glitch", 8'h55, 1'b0, 1'b0);

        hold(1'b0, 20 * bit_clk);
        hold(1'b1, 2 * bit_clk);
        expect_frame("break", 8'h00, 1'b1, 1'b0);
        expect_none("break_extra");
        send(8'h81, 1'b1);
        expect_frame("post_break", 8'h81, 1'b0, 1'b0);

        pat = 8'h5A;
        hold(1'b0, bit_clk);
        for (int i = 0; i < 3; i++) hold(pat[i], bit_clk);
        reset = 1'b0;
        hold(1'b1, 3);
        chk("midrst_dout", 32'(bus.dout), 32'd0);
        chk("midrst_done", 32'(bus.rx_done_tick), 32'd0);
        chk("midrst_ferr", 32'(bus.frame_err), 32'd0);
        reset = 1'b1;
        hold(1'b1, 2 * bit_clk);
        expect_none("midrst_nostrobe");
        send(8'h5A, 1'b1);
        expect_frame("resend", 8'h5A, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            set_dvsr(DVSR_W'($urandom_range(0, 5)));
            rd = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send(rd, rs);
            hold(1'b1, bit_clk);
            expect_frame("rand", rd, ~rs, 1'b0);
        end

`ifdef UART_RX_PARITY_EN
        set_dvsr(11'd3);
        send_par(8'h07, 1'b1);
        expect_frame("par_ok", 8'h07, 1'b0, 1'b0);
        send_par(8'h07, 1'b0);
        expect_frame("par_bad", 8'h07, 1'b0, 1'b1);
        set_dvsr(11'd650);
        send(8'h41, 1'b1);
        expect_frame("slow", 8'h41, 1'b0, 1'b0);
`endif

        hold(1'b1, 2 * bit_clk);
        expect_none("final_extra");
        chk("no_back2back", 32'(back2back), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
